// File: rtl/register_bank.sv
// register_bank: MIPS general-purpose register file.
// Write-back port, two combinational read ports with same-cycle bypass,
// register 0 hardwired to zero, and a valid/ready dump sequencer that
// streams every register to the debug unit.
module register_bank #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 5
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NB_ADDR-1:0] i_rs_addr,
  input  logic [NB_ADDR-1:0] i_rt_addr,
  output logic [NB_DATA-1:0] o_rs_data,
  output logic [NB_DATA-1:0] o_rt_data,
  input  logic [NB_DATA-1:0] i_write_data,
  input  logic [NB_ADDR-1:0] i_reg2write,
  input  logic               i_regWrite,
  input  logic               i_dump_start,
  input  logic               i_dump_ready,
  output logic               o_dump_valid,
  output logic [NB_ADDR-1:0] o_dump_addr,
  output logic [NB_DATA-1:0] o_dump_data,
  output logic               o_dump_done,
  output logic               o_busy
);

  localparam int                 NREGS    = 1 << NB_ADDR;
  localparam logic [NB_ADDR-1:0] LAST_IDX = NB_ADDR'(NREGS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  logic [NB_DATA-1:0] regs [NREGS];
  state_t             state;
  logic [NB_ADDR-1:0] dump_idx;

  // Shared read rule: r0 is zero, a pending write-back to the same
  // address wins over the stored value, otherwise the stored value.
  function automatic logic [NB_DATA-1:0] read_port(
    input logic [NB_ADDR-1:0] addr,
    input logic [NB_DATA-1:0] stored,
    input logic               we,
    input logic [NB_ADDR-1:0] waddr,
    input logic [NB_DATA-1:0] wdata
  );
    if (addr == '0)
      return '0;
    else if (we && (waddr == addr))
      return wdata;
    else
      return stored;
  endfunction

  // Register array: write-back on the rising edge, r0 never written.
  // NOTE: the array sits behind an async reset because a reset must clear
  // every register; this prevents mapping it onto a RAM macro, which is
  // acceptable for a 32-entry flop-based register file.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (i_regWrite && (i_reg2write != '0)) begin
      regs[i_reg2write] <= i_write_data;
    end
  end

  // Dump sequencer: walks index 0..NREGS-1 once, advancing on each transfer.
  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      dump_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_dump_start) begin
            state    <= SEND;
            dump_idx <= '0;
          end
        end
        SEND: begin
          if (i_dump_ready) begin
            if (dump_idx == LAST_IDX)
              state <= DONE;
            else
              dump_idx <= dump_idx + NB_ADDR'(1);
          end
        end
        DONE: begin
          state    <= IDLE;
          dump_idx <= '0;
        end
        default: begin
          state    <= IDLE;
          dump_idx <= '0;
        end
      endcase
    end
  end

  // Read ports and dump data are purely combinational from addresses,
  // stored state and the write-back inputs.
  assign o_rs_data   = read_port(i_rs_addr, regs[i_rs_addr], i_regWrite,
                                 i_reg2write, i_write_data);
  assign o_rt_data   = read_port(i_rt_addr, regs[i_rt_addr], i_regWrite,
                                 i_reg2write, i_write_data);
  assign o_dump_data = read_port(dump_idx, regs[dump_idx], i_regWrite,
                                 i_reg2write, i_write_data);

  // Handshake flags decode registered state only; no path from i_dump_ready.
  assign o_dump_valid = (state == SEND);
  assign o_busy       = (state == SEND);
  assign o_dump_done  = (state == DONE);
  assign o_dump_addr  = dump_idx;

endmodule

// File: tb/tb_register_bank.sv
// tb_register_bank: table-driven vectors, randomized reads/writes against an
// array model, and hand-written dump sequences (full, backpressure, reset).
module tb_register_bank;

  localparam int NB_DATA = 32;
  localparam int NB_ADDR = 5;
  localparam int NREGS   = 32;

  logic               i_clk = 1'b0;
  logic               i_rst_n;
  logic [NB_ADDR-1:0] i_rs_addr;
  logic [NB_ADDR-1:0] i_rt_addr;
  logic [NB_DATA-1:0] o_rs_data;
  logic [NB_DATA-1:0] o_rt_data;
  logic [NB_DATA-1:0] i_write_data;
  logic [NB_ADDR-1:0] i_reg2write;
  logic               i_regWrite;
  logic               i_dump_start;
  logic               i_dump_ready;
  logic               o_dump_valid;
  logic [NB_ADDR-1:0] o_dump_addr;
  logic [NB_DATA-1:0] o_dump_data;
  logic               o_dump_done;
  logic               o_busy;

  register_bank #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_rs_addr    (i_rs_addr),
    .i_rt_addr    (i_rt_addr),
    .o_rs_data    (o_rs_data),
    .o_rt_data    (o_rt_data),
    .i_write_data (i_write_data),
    .i_reg2write  (i_reg2write),
    .i_regWrite   (i_regWrite),
    .i_dump_start (i_dump_start),
    .i_dump_ready (i_dump_ready),
    .o_dump_valid (o_dump_valid),
    .o_dump_addr  (o_dump_addr),
    .o_dump_data  (o_dump_data),
    .o_dump_done  (o_dump_done),
    .o_busy       (o_busy)
  );

  always #5 i_clk = ~i_clk;

  int tests = 0;
  int fails = 0;

  // Reference contents of the register file.
  logic [NB_DATA-1:0] mem [NREGS];

  typedef struct {
    logic               we;
    logic [NB_ADDR-1:0] wa;
    logic [NB_DATA-1:0] wd;
    logic [NB_ADDR-1:0] rs;
    logic [NB_ADDR-1:0] rt;
    logic [NB_DATA-1:0] exp_rs;
    logic [NB_DATA-1:0] exp_rt;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [NB_DATA-1:0] act,
                       input logic [NB_DATA-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Value a read of address a must return right now, from the model.
  function automatic logic [NB_DATA-1:0] model_read(input logic [NB_ADDR-1:0] a);
    if (a == 0) return '0;
    if (i_regWrite && i_reg2write == a) return i_write_data;
    return mem[a];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < NREGS; i++) mem[i] = '0;
  endtask

  // One rising edge; the model commits the write held across it.
  task automatic tick();
    @(posedge i_clk);
    if (i_rst_n && i_regWrite && i_reg2write != 0) mem[i_reg2write] = i_write_data;
    #1;
  endtask

  task automatic quiet();
    i_regWrite   = 1'b0;
    i_reg2write  = '0;
    i_write_data = '0;
    i_dump_start = 1'b0;
  endtask

  task automatic write_reg(input logic [NB_ADDR-1:0] a, input logic [NB_DATA-1:0] d);
    i_regWrite = 1'b1; i_reg2write = a; i_write_data = d;
    tick();
    i_regWrite = 1'b0;
  endtask

  task automatic start_dump();
    i_dump_start = 1'b1;
    tick();
    i_dump_start = 1'b0;
  endtask

  initial begin
    int xfers;
    logic wrote;

    vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 5'd0,  32'h12345678, 5'd0,  5'd0,  32'h0,        32'h0};
    vecs[3] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd5,  32'h0,        32'hDEADBEEF};
    vecs[4] = '{1'b1, 5'd7,  32'h11,       5'd7,  5'd6,  32'h11,       32'h0};
    vecs[5] = '{1'b1, 5'd7,  32'h22,       5'd7,  5'd7,  32'h22,       32'h22};
    vecs[6] = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd5,  32'h22,       32'hDEADBEEF};
    vecs[7] = '{1'b1, 5'd31, 32'hFFFFFFFF, 5'd31, 5'd30, 32'hFFFFFFFF, 32'h0};
    vecs[8] = '{1'b0, 5'd31, 32'h0,        5'd31, 5'd1,  32'hFFFFFFFF, 32'h0};

    // Reset state
    i_rst_n = 1'b0;
    quiet();
    i_dump_ready = 1'b0;
    i_rs_addr = 5'd3;
    i_rt_addr = 5'd31;
    clear_model();
    #2;
    check("rst_valid", 32'(o_dump_valid), 32'd0);
    check("rst_done",  32'(o_dump_done),  32'd0);
    check("rst_busy",  32'(o_busy),       32'd0);
    check("rst_addr",  32'(o_dump_addr),  32'd0);
    check("rst_rs",    o_rs_data,         32'd0);
    check("rst_rt",    o_rt_data,         32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    tick();

    // Table-driven writes/reads including r0 and bypass
    for (int i = 0; i < 9; i++) begin
      i_regWrite = vecs[i].we; i_reg2write = vecs[i].wa; i_write_data = vecs[i].wd;
      i_rs_addr = vecs[i].rs;  i_rt_addr = vecs[i].rt;
      #1;
      check($sformatf("vec%0d_rs", i), o_rs_data, vecs[i].exp_rs);
      check($sformatf("vec%0d_rt", i), o_rt_data, vecs[i].exp_rt);
      tick();
    end
    quiet();

    // Randomized traffic against the array model
    for (int i = 0; i < 200; i++) begin
      i_regWrite   = 1'($urandom_range(0, 1));
      i_reg2write  = 5'($urandom_range(0, NREGS - 1));
      i_write_data = $urandom;
      i_rs_addr    = 5'($urandom_range(0, NREGS - 1));
      i_rt_addr    = (i % 4 == 0) ? i_reg2write : 5'($urandom_range(0, NREGS - 1));
      #1;
      check($sformatf("rand%0d_rs", i), o_rs_data, model_read(i_rs_addr));
      check($sformatf("rand%0d_rt", i), o_rt_data, model_read(i_rt_addr));
      tick();
    end
    quiet();

    // Asynchronous reset mid-cycle clears everything without an edge
    write_reg(5'd5, 32'hCAFE0005);
    write_reg(5'd7, 32'hCAFE0007);
    i_rs_addr = 5'd5; i_rt_addr = 5'd7;
    #1;
    check("pre_rst_rs", o_rs_data, 32'hCAFE0005);
    i_rst_n = 1'b0;
    #1;
    clear_model();
    check("async_rst_rs",    o_rs_data,         32'd0);
    check("async_rst_rt",    o_rt_data,         32'd0);
    check("async_rst_busy",  32'(o_busy),       32'd0);
    check("async_rst_valid", 32'(o_dump_valid), 32'd0);
    #1;
    i_rst_n = 1'b1;
    tick();

    // Full dump with ready held high
    for (int n = 1; n < NREGS; n++) write_reg(5'(n), 32'(n * 32'h100));
    i_dump_ready = 1'b1;
    start_dump();
    for (int k = 0; k < NREGS; k++) begin
      check($sformatf("full%0d_valid", k), 32'(o_dump_valid), 32'd1);
      check($sformatf("full%0d_addr", k),  32'(o_dump_addr),  32'(k));
      check($sformatf("full%0d_data", k),  o_dump_data,       32'(k * 32'h100));
      tick();
    end
    check("full_done",       32'(o_dump_done),  32'd1);
    check("full_done_valid", 32'(o_dump_valid), 32'd0);
    check("full_done_busy",  32'(o_busy),       32'd0);
    tick();
    check("full_done_pulse", 32'(o_dump_done),  32'd0);
    check("full_idle_busy",  32'(o_busy),       32'd0);

    // Backpressure, write during a held word, ignored start mid-dump
    start_dump();
    xfers = 0;
    wrote = 1'b0;
    for (int c = 0; c < 200 && xfers < NREGS; c++) begin
      i_dump_ready = (c % 4 == 0) || (c % 4 == 3);
      i_regWrite   = 1'b0;
      i_dump_start = (xfers == 16);
      if (xfers == 3 && !i_dump_ready && !wrote) begin
        i_regWrite = 1'b1; i_reg2write = 5'd3; i_write_data = 32'hAA;
        wrote = 1'b1;
      end
      #1;
      check($sformatf("bp_c%0d_valid", c), 32'(o_dump_valid), 32'd1);
      check($sformatf("bp_c%0d_addr", c),  32'(o_dump_addr),  32'(xfers));
      check($sformatf("bp_c%0d_data", c),  o_dump_data,       model_read(5'(xfers)));
      if (i_dump_ready) begin
        if (xfers == 3) check("bp_word3", o_dump_data, 32'hAA);
        xfers++;
      end
      tick();
    end
    quiet();
    i_dump_ready = 1'b1;
    check("bp_transfers", 32'(xfers), 32'(NREGS));
    check("bp_done",      32'(o_dump_done),  32'd1);
    tick();
    check("bp_no_restart_valid", 32'(o_dump_valid), 32'd0);
    check("bp_no_restart_done",  32'(o_dump_done),  32'd0);

    // Reset asserted at word 10 aborts the dump
    start_dump();
    for (int k = 0; k < 10; k++) tick();
    check("mid_addr10", 32'(o_dump_addr), 32'd10);
    i_rst_n = 1'b0;
    #1;
    clear_model();
    check("mid_rst_valid", 32'(o_dump_valid), 32'd0);
    check("mid_rst_busy",  32'(o_busy),       32'd0);
    check("mid_rst_done",  32'(o_dump_done),  32'd0);
    check("mid_rst_addr",  32'(o_dump_addr),  32'd0);
    #1;
    i_rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("mid_after%0d_done", k), 32'(o_dump_done), 32'd0);
      check($sformatf("mid_after%0d_busy", k), 32'(o_busy),      32'd0);
    end
    start_dump();
    for (int k = 0; k < NREGS; k++) begin
      check($sformatf("re%0d_addr", k), 32'(o_dump_addr), 32'(k));
      check($sformatf("re%0d_data", k), o_dump_data,      32'd0);
      tick();
    end
    check("re_done", 32'(o_dump_done), 32'd1);
    tick();
    check("re_idle", 32'(o_busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/register_bank.md
# register_bank

General-purpose register file of the MIPS pipeline: the receiving end of the write-back interface, which delivers data, destination register and write enable. It holds 2^NB_ADDR registers of NB_DATA bits, with register 0 hardwired to zero. It serves two combinational read ports to the ID stage, with same-cycle write-to-read bypass. A dump sequencer streams every register over a valid/ready handshake to the debug unit.

## Interface
- NB_DATA, 32, data width of each register
- NB_ADDR, 5, register address width (2^NB_ADDR registers)

- i_clk  input  1  clock; all state changes on rising edge
- i_rst_n  input  1  asynchronous active-low reset
- i_rs_addr  input  NB_ADDR  read port A address
- i_rt_addr  input  NB_ADDR  read port B address
- o_rs_data  output  NB_DATA  read port A data (combinational)
- o_rt_data  output  NB_DATA  read port B data (combinational)
- i_write_data  input  NB_DATA  write-back data
- i_reg2write  input  NB_ADDR  write-back destination register
- i_regWrite  input  1  write-back enable
- i_dump_start  input  1  starts a full register dump; sampled only in IDLE
- i_dump_ready  input  1  debug unit accepts the current dump word
- o_dump_valid  output  1  dump word valid
- o_dump_addr  output  NB_ADDR  index of the current dump word
- o_dump_data  output  NB_DATA  content of register o_dump_addr
- o_dump_done  output  1  one-cycle pulse after the last word transfers
- o_busy  output  1  high while a dump is in progress (state SEND)

## Operation
- Reset (i_rst_n=0, asynchronous):
  - all registers cleared to 0
  - FSM goes to IDLE, dump index 0
  - outputs: o_dump_valid=0, o_dump_done=0, o_busy=0, o_dump_addr=0
- Write:
  - on a rising edge with i_regWrite=1 and i_reg2write!=0, the register at i_reg2write takes i_write_data
  - writes to register 0 are discarded
- Read (same rule for each port and for the dump port):
  - address 0 -> 0
  - else if i_regWrite=1 and i_reg2write equals the address -> i_write_data (bypass)
  - else -> stored value
- Dump FSM: IDLE, SEND, DONE.
  - IDLE: i_dump_start=1 -> SEND with index=0. Otherwise stay.
  - SEND: o_dump_valid=1, o_busy=1, o_dump_addr=index, o_dump_data=read(index).
    - Transfer occurs when o_dump_valid and i_dump_ready are both high.
    - Transfer with index<2^NB_ADDR-1 -> index+1.
    - Transfer with index=2^NB_ADDR-1 -> DONE. The index does not wrap into a second pass.
    - No transfer -> hold index; data tracks register contents, including writes.
  - DONE: o_dump_done=1 for exactly one cycle, o_dump_valid=0 -> IDLE with index reset to 0.
  - i_dump_start is ignored in SEND and DONE.
- Write-back writes are never stalled by a dump. Each word reflects the register value in its own transfer cycle, bypass included.

## Timing
- Read ports and dump data: zero latency (combinational from address and write-back inputs).
- Write visible through stored state from the cycle after the edge; visible via bypass in the same cycle.
- Dump with i_dump_ready constantly high:
  - start sampled at edge 0
  - valid from cycle 1 through cycle 2^NB_ADDR (32 cycles)
  - o_dump_done high in cycle 2^NB_ADDR+1
  - IDLE in the next cycle, when a new start may be accepted
- o_dump_valid, o_busy and o_dump_done are decoded from registered state only; there is no combinational path from i_dump_ready.
- Reset asserted mid-dump aborts immediately: no done pulse, registers cleared.

## Test plan
- Reset: write several registers, pulse i_rst_n low mid-cycle.
  - Required: all reads return 0, o_busy=0, o_dump_valid=0 immediately, without waiting for a clock edge.
- Write/read: write 0xDEADBEEF to r5; next cycle read rs=5, rt=5.
  - Required: both ports 0xDEADBEEF.
  - Also write 0x12345678 to r0, then read r0. Required: 0.
- Bypass: r7 holds 0x11; same cycle write 0x22 to r7 while reading rs=7.
  - Required: o_rs_data=0x22 in that cycle, and 0x22 afterward.
- Full dump, ready high: preload r[n]=n*0x100, pulse start.
  - Required: 32 consecutive words with o_dump_addr 0..31 and data 0,0x100,…,0x1F00 (r0 reads 0).
  - Required: o_dump_done exactly one cycle after word 31.
- Backpressure and concurrency: toggle i_dump_ready 1,0,0,1…; write r3=0xAA while word 3 is held; pulse i_dump_start mid-dump.
  - Required: index holds while ready=0; word 3 transfers as 0xAA; no restart; exactly 32 transfers.
- Reset mid-dump: assert i_rst_n low at word 10.
  - Required: no done pulse, FSM in IDLE, index 0.
  - Required: a following start dumps from address 0 with all-zero data.
